uart_tx_sched: RTL

UART transmit scheduler sitting directly in front of `uart_tx`. It accepts bytes from two requesters and sequences them onto the single serial transmitter, one frame at a time, with round-robin fairness:

- **SDRAM read-data path:** buffered in an internal FIFO.
- **Command-response path:** single-byte valid/ready handshake.

It generates the one-cycle `tx_flag` start pulse and holds `tx_data` stable for the whole frame. Because `uart_tx` has no done output, the scheduler times each frame itself.

---
 rtl/uart_tx_sched.sv | 105 ++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding one uart_tx from a 16-deep byte FIFO and a cmd valid/ready port.
// Grant at t -> tx_flag/tx_data at t+1, next grant >= FRAME_CYC+2 later; cmd_ready only in IDLE, FIFO drops pushes when full.
module uart_tx_sched #(
    parameter int BAUD_END = 5208,
    parameter int BIT_END  = 10,
    parameter int GAP_CYC  = 2,
    parameter int FIFO_AW  = 4
) (
    input  logic               sclk,
    input  logic               s_rst,
    input  logic               rd_wr_en,
    input  logic [7:0]         rd_wr_data,
    output logic               fifo_full,
    output logic [FIFO_AW:0]   fifo_cnt,
    output logic               fifo_ovf,
    input  logic               cmd_valid,
    input  logic [7:0]         cmd_data,
    output logic               cmd_ready,
    output logic               tx_flag,
    output logic [7:0]         tx_data,
    output logic               busy
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [16:0]        FRAME_LAST = 17'(BAUD_END * BIT_END + GAP_CYC - 1);
    localparam logic [FIFO_AW:0]   DEPTH_CNT  = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   CNT_ONE    = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ONE    = {{(FIFO_AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
    typedef enum logic {SRC_FIFO, SRC_CMD} src_t;

    state_t             state, state_nxt;
    src_t               last_grant;
    logic [16:0]        wait_cnt;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic               fifo_pend, grant_fifo, grant_cmd, push_ok;

    assign fifo_full  = (fifo_cnt == DEPTH_CNT);
    assign fifo_pend  = (fifo_cnt != '0);
    // On a tie the source that did not win last time is served.
    assign grant_fifo = (state == IDLE) && fifo_pend && (!cmd_valid || last_grant == SRC_CMD);
    assign grant_cmd  = (state == IDLE) && cmd_valid && (!fifo_pend || last_grant == SRC_FIFO);
    assign cmd_ready  = grant_cmd;
    assign push_ok    = rd_wr_en && !fifo_full;
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_fifo || grant_cmd) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (wait_cnt == FRAME_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state      <= IDLE;
            last_grant <= SRC_CMD;
            wait_cnt   <= '0;
            tx_flag    <= 1'b0;
            tx_data    <= 8'h00;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            fifo_ovf   <= 1'b0;
        end else begin
            state   <= state_nxt;
            tx_flag <= grant_fifo || grant_cmd;
            if (grant_fifo) begin
                tx_data    <= mem[rd_ptr];
                last_grant <= SRC_FIFO;
                rd_ptr     <= rd_ptr + PTR_ONE;
            end else if (grant_cmd) begin
                tx_data    <= cmd_data;
                last_grant <= SRC_CMD;
            end
            if (state == START) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 17'd1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            // Fullness is judged before the same-cycle pop, so a push at full is lost.
            if (rd_wr_en && fifo_full) begin
                fifo_ovf <= 1'b1;
            end
            case ({push_ok, grant_fifo})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge sclk) begin
        if (push_ok) begin
            mem[wr_ptr] <= rd_wr_data;
        end
    end
endmodule
